instr_encoder: RTL and testbench

Pipelined RV32I instruction encoder, the inverse of the immediate generator. It takes decoded fields (opcode, registers, funct codes, and a flat 32-bit immediate) and scatters the immediate bits into the correct I/S/B/U/J positions. Each assembled 32-bit word is emitted with a word-aligned write address from an internal counter. It sits in front of instruction memory as the loader/self-test path and drives memory writes through a valid/ready handshake.

---
 rtl/instr_encoder.sv | 123 ++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-to-word encoder with one output register and an auto-incrementing write address
// Optional range checking on out_err is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_I_JALR = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_U_LUI  = 7'b0110111;
    localparam logic [6:0] OP_U_AUI  = 7'b0010111;
    localparam logic [6:0] OP_J      = 7'b1101111;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic [31:0]       enc;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              taken;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign taken    = out_valid && out_ready;
    assign out_addr = addr_q;

    always_comb begin
        enc = NOP;
        case (in_opcode)
            OP_R:
                enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            OP_I_ALU, OP_I_LOAD, OP_I_JALR:
                enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            OP_S:
                enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            OP_B:
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
            OP_U_LUI, OP_U_AUI:
                enc = {in_imm[31:12], in_rd, in_opcode};
            OP_J:
                enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default:
                enc = NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            addr_q    <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= enc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Clear wins over increment; the word leaving this cycle already saw the old address.
            if (addr_clr) begin
                addr_q <= '0;
            end else if (taken) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
        end
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic err_c;
    logic err_q;

    always_comb begin
        err_c = 1'b0;
        case (in_opcode)
            OP_R:
                err_c = 1'b0;
            OP_I_ALU, OP_I_LOAD, OP_I_JALR, OP_S:
                err_c = (in_imm[31:11] != {21{in_imm[11]}});
            OP_B:
                err_c = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            OP_U_LUI, OP_U_AUI:
                err_c = (in_imm[11:0] != 12'h0);
            OP_J:
                err_c = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            default:
                err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= err_c;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed and randomized checks of instr_encoder against an arithmetic reference model
module tb_instr_encoder;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          addr_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_i;
    logic        exp_e;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .addr_clr(addr_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] model_enc(int unsigned op, int unsigned rd, int unsigned rs1,
                                              int unsigned rs2, int unsigned f3, int unsigned f7,
                                              int unsigned imm);
        int unsigned regs;
        regs = (rs2 << 20) + (rs1 << 15) + (f3 << 12);
        case (op)
            'h33: return (f7 << 25) + regs + (rd << 7) + op;
            'h13, 'h03, 'h67: return ((imm & 'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
            'h23: return (((imm >> 5) & 'h7F) << 25) + regs + ((imm & 'h1F) << 7) + op;
            'h63: return (((imm >> 12) & 1) << 31) + (((imm >> 5) & 'h3F) << 25) + regs
                         + (((imm >> 1) & 'hF) << 8) + (((imm >> 11) & 1) << 7) + op;
            'h37, 'h17: return (imm & 'hFFFFF000) + (rd << 7) + op;
            'h6F: return (((imm >> 20) & 1) << 31) + (((imm >> 1) & 'h3FF) << 21)
                         + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 'hFF) << 12) + (rd << 7) + op;
            default: return 32'h00000013;
        endcase
    endfunction

    function automatic logic model_err(int unsigned op, int unsigned imm);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        int s;
        s = int'(imm);
        case (op)
            'h33: return 1'b0;
            'h13, 'h03, 'h67, 'h23: return !(s >= -2048 && s <= 2047);
            'h63: return !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
            'h6F: return !(s >= -(1 << 20) && s <= (1 << 20) - 1) || (imm % 2 != 0);
            'h37, 'h17: return (imm % 4096) != 0;
            default: return 1'b1;
        endcase
`else
        return (op == 'hFFFF_FFFF) && (imm == 'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int unsigned op, input int unsigned rd, input int unsigned rs1,
                       input int unsigned rs2, input int unsigned f3, input int unsigned f7,
                       input int unsigned imm);
        in_opcode = op[6:0]; in_rd = rd[4:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0];
        in_funct3 = f3[2:0]; in_funct7 = f7[6:0]; in_imm = imm;
        in_valid = 1'b1;
        exp_i = model_enc(op, rd, rs1, rs2, f3, f7, imm);
        exp_e = model_err(op, imm);
    endtask

    task automatic word(input string tag, input logic [31:0] instr, input logic [AW-1:0] addr,
                        input logic err);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".instr"}, out_instr, instr);
        chk({tag, ".addr"}, 32'(out_addr), 32'(addr));
        chk({tag, ".err"}, 32'(out_err), 32'(err));
    endtask

    task automatic do_reset();
        in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    int unsigned ops [11] = '{'h33, 'h13, 'h03, 'h67, 'h23, 'h63, 'h37, 'h17, 'h6F, 'h00, 'h7F};

    initial begin
        logic [31:0] held;
        logic        m_valid, m_err, iv, orr, ac, taken, acc;
        logic [31:0] m_instr;
        int unsigned m_addr, op, imm;

        do_reset();
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.instr", out_instr, 0);
        chk("rst.err", 32'(out_err), 0);
        chk("rst.addr", 32'(out_addr), 0);
        chk("rst.in_ready", 32'(in_ready), 1);

        // addi x1,x0,5
        out_ready = 1'b1;
        req('h13, 1, 0, 0, 0, 0, 5);
        step();
        in_valid = 1'b0;
        word("addi", 32'h00500093, 0, 1'b0);
        chk("addi.model", exp_i, 32'h00500093);

        // sw / beq / jal back to back
        do_reset();
        out_ready = 1'b1;
        req('h23, 0, 1, 2, 2, 0, 8);
        step();
        word("sw", 32'h0020A423, 'h0, exp_e);
        req('h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC);
        step();
        word("beq", 32'hFE000EE3, 'h4, exp_e);
        req('h6F, 0, 0, 0, 0, 0, 32'hFFFFFFF8);
        step();
        word("jal", 32'hFF9FF06F, 'h8, exp_e);
        in_valid = 1'b0;
        step();
        chk("b2b.drain", 32'(out_valid), 0);

        // stall for three cycles with a second request waiting
        do_reset();
        req('h13, 1, 0, 0, 0, 0, 5);
        step();
        held = out_instr;
        req('h23, 0, 1, 2, 2, 0, 8);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.in_ready", 32'(in_ready), 0);
            word("stall", 32'h00500093, 0, 1'b0);
            step();
        end
        chk("stall.stable", out_instr, held);
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        word("release", exp_i, 'h4, exp_e);
        step();
        chk("release.drain", 32'(out_valid), 0);

        // wrap at 2^AW
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req('h33, i, i + 1, i + 2, i, 'h20, 0);
            step();
            word("wrap", exp_i, AW'((4 * i) % 16), 1'b0);
        end
        in_valid = 1'b0;
        step();

        // addr_clr pulsed with the third handshake
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) addr_clr = 1'b1;
            req('h37, i, 0, 0, 0, 0, 32'h12345000 + i * 32'h1000);
            step();
            addr_clr = 1'b0;
            word("clr", exp_i, (i == 3) ? 4'h0 : AW'(4 * i), exp_e);
        end
        in_valid = 1'b0;
        step();
        chk("clr.after", 32'(out_addr), 'h4);

        // range-check boundary stimulus
        req('h13, 1, 0, 0, 0, 0, 2048);
        step();
        word("addi2048", 32'h80000093, out_addr, exp_e);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        chk("addi2048.err_set", 32'(exp_e), 1);
`endif
        req('h6F, 0, 0, 0, 0, 0, 5);
        step();
        word("jal_odd", exp_i, out_addr, exp_e);
        req('h00, 3, 4, 5, 6, 7, 99);
        step();
        word("badop", 32'h00000013, out_addr, exp_e);

        // reset while stalled
        out_ready = 1'b0;
        req('h13, 1, 0, 0, 0, 0, 5);
        step();
        in_valid = 1'b0;
        chk("pre_rst.valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(out_valid), 0);
        chk("async_rst.addr", 32'(out_addr), 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        req('h13, 2, 0, 0, 0, 0, 7);
        step();
        in_valid = 1'b0;
        word("post_rst", exp_i, 0, exp_e);
        step();

        // randomized traffic against the model
        do_reset();
        m_valid = 1'b0; m_instr = '0; m_err = 1'b0; m_addr = 0;
        for (int n = 0; n < 300; n++) begin
            iv  = ($urandom_range(0, 9) < 7);
            orr = ($urandom_range(0, 1) == 1);
            ac  = ($urandom_range(0, 19) == 0);
            op  = ops[$urandom_range(0, 10)];
            imm = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096;
            req(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 7), $urandom_range(0, 127), imm);
            in_valid = iv; out_ready = orr; addr_clr = ac;
            #1;
            chk("rnd.in_ready", 32'(in_ready), 32'(!m_valid || orr));
            taken = m_valid && orr;
            acc = iv && (!m_valid || orr);
            if (acc) begin
                m_valid = 1'b1; m_instr = exp_i; m_err = exp_e;
            end else if (taken) begin
                m_valid = 1'b0;
            end
            if (ac) m_addr = 0;
            else if (taken) m_addr = (m_addr + 4) % (1 << AW);
            step();
            chk("rnd.valid", 32'(out_valid), 32'(m_valid));
            chk("rnd.addr", 32'(out_addr), m_addr);
            if (m_valid) begin
                chk("rnd.instr", out_instr, m_instr);
                chk("rnd.err", 32'(out_err), 32'(m_err));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
